core: RTL and testbench

Single-cycle RV32I-subset processor with an internal unified byte-addressed main memory. Each instruction is fetched, decoded, executed and retired in one clock cycle. The core has no data ports: programs and data are preloaded into the memory array (`MainMemory.data_RAM`) by hierarchical access, and results are inspected in the register file and memory.

---
 rtl/core.sv | 130 +++++++++++++
 tb/tb_core.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core.sv
// core: single-cycle RV32I-subset processor with unified big-endian byte memory.
// Define CORE_DEBUG_EN to expose dbg_pc/dbg_instr.
module core_mem #(
    parameter int MEM_BYTES = 1024,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-3:0] iaddr,
    input  logic [AW-3:0] daddr,
    input  logic [31:0]   wdata,
    output logic [31:0]   instr,
    output logic [31:0]   rdata
);
    logic [7:0] data_RAM [0:MEM_BYTES-1];
    assign instr = {data_RAM[{iaddr, 2'd0}], data_RAM[{iaddr, 2'd1}], data_RAM[{iaddr, 2'd2}], data_RAM[{iaddr, 2'd3}]};
    assign rdata = {data_RAM[{daddr, 2'd0}], data_RAM[{daddr, 2'd1}], data_RAM[{daddr, 2'd2}], data_RAM[{daddr, 2'd3}]};
    always_ff @(posedge clock) begin
        if (we) begin
            data_RAM[{daddr, 2'd0}] <= wdata[31:24];
            data_RAM[{daddr, 2'd1}] <= wdata[23:16];
            data_RAM[{daddr, 2'd2}] <= wdata[15:8];
            data_RAM[{daddr, 2'd3}] <= wdata[7:0];
        end
    end
endmodule

module core #(
    parameter int          MEM_BYTES = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
`ifdef CORE_DEBUG_EN
    output logic [31:0] dbg_pc,
    output logic [31:0] dbg_instr,
`endif
    input  logic        mem_en
);
    localparam int AW = $clog2(MEM_BYTES);

    logic [31:0] pc, instr, load_data, rs1_val, rs2_val, op_b, alu, sra_res, addr, wdata, next_pc, pc_plus4;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] regs [0:31];
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  f3;
    logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, taken, reg_we, store, unused_bits;

    core_mem #(.MEM_BYTES(MEM_BYTES)) MainMemory (
        .clock(clock),
        .we(store),
        .iaddr(pc[AW-1:2]),
        .daddr(addr[AW-1:2]),
        .wdata(rs2_val),
        .instr(instr),
        .rdata(load_data)
    );

`ifdef CORE_DEBUG_EN
    assign dbg_pc    = pc;
    assign dbg_instr = instr;
`endif

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};

    // Unsupported encodings fall out of every is_* flag and retire as NOPs
    assign is_r    = opcode == 7'h33 && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
    assign is_i    = opcode == 7'h13 && ((f3 == 3'b001) ? (f7 == 7'h00) :
                                         (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1);
    assign is_lw   = opcode == 7'h03 && f3 == 3'b010;
    assign is_sw   = opcode == 7'h23 && f3 == 3'b010;
    assign is_br   = opcode == 7'h63 && (f3 == 3'b000 || f3 == 3'b001);
    assign is_jal  = opcode == 7'h6f;
    assign is_jalr = opcode == 7'h67 && f3 == 3'b000;
    assign is_lui  = opcode == 7'h37;

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign op_b    = is_r ? rs2_val : imm_i;
    assign shamt   = op_b[4:0];
    assign sra_res = $signed(rs1_val) >>> shamt;

    always_comb begin
        case (f3)
            3'b000:  alu = (is_r && f7[5]) ? rs1_val - op_b : rs1_val + op_b;
            3'b001:  alu = rs1_val << shamt;
            3'b010:  alu = {31'd0, $signed(rs1_val) < $signed(op_b)};
            3'b011:  alu = {31'd0, rs1_val < op_b};
            3'b100:  alu = rs1_val ^ op_b;
            3'b101:  alu = f7[5] ? sra_res : rs1_val >> shamt;
            3'b110:  alu = rs1_val | op_b;
            default: alu = rs1_val & op_b;
        endcase
    end

    assign addr     = rs1_val + (is_sw ? imm_s : imm_i);
    assign pc_plus4 = pc + 32'd4;
    assign taken    = is_br && (f3[0] ? rs1_val != rs2_val : rs1_val == rs2_val);
    assign next_pc  = is_jal  ? pc + imm_j :
                      is_jalr ? (rs1_val + imm_i) & ~32'd1 :
                      taken   ? pc + imm_b : pc_plus4;
    assign wdata    = is_lui ? imm_u : (is_jal || is_jalr) ? pc_plus4 : is_lw ? load_data : alu;
    assign reg_we   = (is_r || is_i || is_lw || is_jal || is_jalr || is_lui) && rd != 5'd0;
    assign store    = reset && mem_en && is_sw;

    // Memory wraps modulo MEM_BYTES and accesses are word aligned
    assign unused_bits = ^{addr[31:AW], addr[1:0], pc[31:AW], pc[1:0]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (mem_en) begin
            pc <= next_pc;
            if (reg_we) regs[rd] <= wdata;
        end
    end
endmodule

// File: tb/tb_core.sv
// tb_core: randomized scoreboard bench for core against an instruction-level reference model.
module tb_core;
    localparam int MEM = 1024;

    typedef struct packed {
        logic [31:0]   pc;
        logic [1023:0] r;
        logic [31:0]   maddr;
        logic [31:0]   mword;
    } exp_t;

    logic clock = 1'b0, reset = 1'b0, mem_en = 1'b0;
    int n_checks = 0, n_fail = 0;
    logic [31:0] m_pc = 32'd0, m_last = 32'h100;
    logic [31:0] m_regs [32];
    logic [7:0]  m_mem [MEM];
    exp_t q[$];

    core #(.MEM_BYTES(MEM)) dut (
        .clock(clock),
        .reset(reset),
        .mem_en(mem_en)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int b;
        b = int'({a[9:2], 2'b00});
        return {m_mem[b], m_mem[b+1], m_mem[b+2], m_mem[b+3]};
    endfunction

    function automatic logic [31:0] dut_word(input logic [31:0] a);
        int b;
        b = int'({a[9:2], 2'b00});
        return {dut.MainMemory.data_RAM[b], dut.MainMemory.data_RAM[b+1],
                dut.MainMemory.data_RAM[b+2], dut.MainMemory.data_RAM[b+3]};
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        int b;
        b = int'({a[9:2], 2'b00});
        for (int k = 0; k < 4; k++) begin
            m_mem[b+k] = w[31-8*k -: 8];
            dut.MainMemory.data_RAM[b+k] = w[31-8*k -: 8];
        end
    endtask

    // Reference model: one architectural step per clock edge
    task automatic model_edge(input bit rn, input bit en);
        logic [31:0] ins, a, b, res, npc, immi, imms, immb, immj, sra;
        bit wr;
        if (!rn) begin
            m_pc = 32'd0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (en) begin
            ins  = m_word(m_pc);
            a    = m_regs[ins[19:15]];
            b    = m_regs[ins[24:20]];
            immi = 32'($signed(ins[31:20]));
            imms = 32'($signed({ins[31:25], ins[11:7]}));
            immb = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            immj = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            npc  = m_pc + 32'd4;
            wr   = 1'b0;
            res  = 32'd0;
            case (ins[6:0])
                7'h33: begin
                    wr  = 1'b1;
                    sra = $signed(a) >>> b[4:0];
                    case ({ins[31:25], ins[14:12]})
                        10'h000: res = a + b;
                        10'h100: res = a - b;
                        10'h001: res = a << b[4:0];
                        10'h002: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        10'h003: res = (a < b) ? 32'd1 : 32'd0;
                        10'h004: res = a ^ b;
                        10'h005: res = a >> b[4:0];
                        10'h105: res = sra;
                        10'h006: res = a | b;
                        10'h007: res = a & b;
                        default: wr = 1'b0;
                    endcase
                end
                7'h13: begin
                    wr  = 1'b1;
                    sra = $signed(a) >>> ins[24:20];
                    case (ins[14:12])
                        3'd0: res = a + immi;
                        3'd2: res = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
                        3'd3: res = (a < immi) ? 32'd1 : 32'd0;
                        3'd4: res = a ^ immi;
                        3'd6: res = a | immi;
                        3'd7: res = a & immi;
                        3'd1: if (ins[31:25] == 7'h00) res = a << ins[24:20]; else wr = 1'b0;
                        default: if (ins[31:25] == 7'h00) res = a >> ins[24:20];
                                 else if (ins[31:25] == 7'h20) res = sra;
                                 else wr = 1'b0;
                    endcase
                end
                7'h03: if (ins[14:12] == 3'd2) begin wr = 1'b1; res = m_word(a + immi); end
                7'h23: if (ins[14:12] == 3'd2) begin
                    m_last = {22'd0, 8'(((a + imms) >> 2)), 2'b00};
                    put(a + imms, b);
                end
                7'h63: begin
                    if (ins[14:12] == 3'd0 && a == b) npc = m_pc + immb;
                    if (ins[14:12] == 3'd1 && a != b) npc = m_pc + immb;
                end
                7'h6f: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + immj; end
                7'h67: if (ins[14:12] == 3'd0) begin wr = 1'b1; res = m_pc + 32'd4; npc = (a + immi) & ~32'd1; end
                7'h37: begin wr = 1'b1; res = {ins[31:12], 12'd0}; end
                default: ;
            endcase
            if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
            m_pc = npc;
        end
    endtask

    task automatic cycle(input bit rn, input bit en);
        exp_t e;
        @(negedge clock);
        #1;
        reset  = rn;
        mem_en = en;
        model_edge(rn, en);
        e.pc = m_pc;
        for (int i = 0; i < 32; i++) e.r[i*32 +: 32] = m_regs[i];
        e.maddr = m_last;
        e.mword = m_word(m_last);
        q.push_back(e);
    endtask

    task automatic run(input int n, input bit en);
        repeat (n) cycle(1'b1, en);
        #5;
    endtask

    // Reset, let the monitor drain, then wipe memory while reset is held
    task automatic begin_prog();
        cycle(1'b0, 1'b0);
        @(negedge clock);
        #1;
        for (int i = 0; i < MEM; i++) begin
            m_mem[i] = 8'h00;
            dut.MainMemory.data_RAM[i] = 8'h00;
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pc", dut.pc, e.pc);
            for (int i = 0; i < 32; i++) check($sformatf("x%0d", i), dut.regs[i], e.r[i*32 +: 32]);
            check("mem", dut_word(e.maddr), e.mword);
        end
    end

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [12:0] off);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        f3  = 3'($urandom);
        case ($urandom_range(0, 11))
            0, 1: return enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
            2, 3: begin
                if (f3 == 3'd1 || f3 == 3'd5) imm = {$urandom_range(0, 1) ? 7'h20 : 7'h00, imm[4:0]};
                return enc_i(7'h13, f3, rd, rs1, imm);
            end
            4:  return enc_i(7'h03, 3'd2, rd, rs1, imm);
            5:  return enc_s(rs2, rs1, imm);
            6:  return enc_b(3'($urandom_range(0, 1)), rs1, rs2, 13'((int'($urandom_range(0, 16)) - 8) * 4));
            7:  return enc_j(rd, 21'((int'($urandom_range(0, 16)) - 8) * 4));
            8:  return enc_i(7'h67, 3'd0, rd, rs1, imm);
            9:  return $urandom;
            10: return {20'($urandom), rd, 7'h37};
            default: return enc_i(7'h13, 3'd0, rd, 5'd0, imm);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        begin_prog();
        put(32'h0, 32'h0000_0000);
        put(32'h4, 32'h0043_0313);
        put(32'h8, 32'h0063_03b3);
        put(32'hC, 32'hff9f_f2ef);
        run(4, 1'b1);
        check("loop_x6", dut.regs[6], 32'd4);
        check("loop_x7", dut.regs[7], 32'd8);
        check("loop_x5", dut.regs[5], 32'h10);
        check("loop_pc", dut.pc, 32'h4);
        run(2, 1'b1);
        check("loop2_x6", dut.regs[6], 32'd8);
        check("loop2_x7", dut.regs[7], 32'd16);

        begin_prog();
        put(32'h4,  enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'h100));
        put(32'h8,  enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'hFFF));
        put(32'hC,  enc_s(5'd2, 5'd1, 12'h0));
        put(32'h10, enc_i(7'h03, 3'd2, 5'd3, 5'd1, 12'h0));
        run(5, 1'b1);
        check("lw_x3", dut.regs[3], 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) check($sformatf("ram_%0h", 32'h100 + i), {24'd0, dut.MainMemory.data_RAM[32'h100 + i]}, 32'hFF);

        begin_prog();
        put(32'h4,  enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5));
        put(32'h8,  enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'd5));
        put(32'hC,  enc_b(3'd0, 5'd1, 5'd2, 13'd8));
        put(32'h10, enc_i(7'h13, 3'd0, 5'd3, 5'd0, 12'd1));
        put(32'h14, enc_b(3'd1, 5'd1, 5'd2, 13'd8));
        put(32'h18, enc_i(7'h13, 3'd0, 5'd4, 5'd0, 12'd2));
        run(6, 1'b1);
        check("beq_skip_x3", dut.regs[3], 32'd0);
        check("bne_fall_x4", dut.regs[4], 32'd2);
        check("br_pc", dut.pc, 32'h1C);

        begin_prog();
        put(32'h4,  enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd7));
        put(32'h8,  32'h8000_00B7);
        put(32'hC,  enc_i(7'h13, 3'd5, 5'd2, 5'd1, 12'h404));
        put(32'h10, enc_i(7'h13, 3'd5, 5'd3, 5'd1, 12'h004));
        run(5, 1'b1);
        check("x0_zero", dut.regs[0], 32'd0);
        check("srai_x2", dut.regs[2], 32'hF800_0000);
        check("srli_x3", dut.regs[3], 32'h0800_0000);
        run(3, 1'b0);
        check("hold_pc", dut.pc, 32'h14);
        check("hold_x2", dut.regs[2], 32'hF800_0000);
        cycle(1'b0, 1'b1);
        #5;
        check("rst_pc", dut.pc, 32'h0);
        check("rst_x1", dut.regs[1], 32'd0);
        check("rst_mem", dut_word(32'h8), 32'h8000_00B7);

        for (int r = 0; r < 5; r++) begin
            begin_prog();
            for (int a = 4; a < 512; a += 4) put(a, rand_instr());
            for (int a = 512; a < MEM; a += 4) put(a, $urandom);
            repeat (300) cycle($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0);
            #5;
        end

        cycle(1'b0, 1'b0);
        @(negedge clock);
        #1;
        check("drain", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
